booth_seq_ctrl: RTL and testbench
=================================

Name: booth_seq_ctrl

Overview:
Control sequencer for the ALU16 radix-2 Booth multiplier. It consumes the 4-bit iteration count from the register-file counter and drives that counter's count enable. It issues load, add, subtract, arithmetic-shift and result-output strobes to the A/Q/M datapath registers. A start/busy/done handshake lets the processor control unit launch one 16x16 multiply and wait for the 32-bit result on the bus.

Parameters:
CNT_W, 4, width of the iteration count input; the last iteration is reached when cnt equals 2^CNT_W-1 (15 by default, giving 16 iterations).

Ports:
clk  in  1  clock; all state changes on the rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  request to begin a multiply; sampled only in IDLE
q0  in  1  LSB of the Q register
q_1  in  1  Booth extra bit Q[-1]
cnt  in  CNT_W  current iteration count from the counter
cnt_clr  out  1  synchronous clear request to the counter
c_up  out  1  count enable to the counter
ld_m  out  1  load M from the multiplicand bus
ld_q  out  1  load Q from the multiplier bus and clear Q[-1]
clr_a  out  1  clear the A register
add  out  1  A <= A + M
sub  out  1  A <= A - M
shift  out  1  arithmetic right shift of {A,Q,Q[-1]}
out_hi  out  1  drive A (product bits 31:16) onto the result bus
out_lo  out  1  drive Q (product bits 15:0) onto the result bus
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse

Behaviour:
- Moore FSM. All outputs decode from the state register only. No output depends combinationally on start.
- States: IDLE, LOAD, CHECK, ADD, SUB, SHIFT, OUT_HI, OUT_LO, DONE.
- Reset (asynchronous, any time, including mid-operation): state goes to IDLE and every output is 0 while rst is high and after it is released. The datapath is not cleared by this block; the next LOAD reinitialises it.
- IDLE: all outputs 0. If start=1, go to LOAD; otherwise stay in IDLE.
- LOAD: ld_m=ld_q=clr_a=cnt_clr=busy=1. Go to CHECK.
- CHECK: busy=1. Next state from {q0,q_1}:
  - 01 -> ADD
  - 10 -> SUB
  - 00 or 11 -> SHIFT
- ADD: add=1, busy=1. Go to SHIFT.
- SUB: sub=1, busy=1. Go to SHIFT.
- SHIFT: shift=1, c_up=1, busy=1. cnt is sampled in the same cycle, i.e. the pre-increment value.
  - cnt == 2^CNT_W-1: go to OUT_HI. The counter wraps to 0 on this edge; this wrap is intended.
  - otherwise: go to CHECK.
- OUT_HI: out_hi=1, busy=1. Go to OUT_LO.
- OUT_LO: out_lo=1, busy=1. Go to DONE.
- DONE: done=1, busy=1. Go to IDLE unconditionally.
- Mutual exclusion: add, sub, shift, out_hi and out_lo are never high in the same cycle.
- start while busy=1 is ignored and is not queued. start held high through DONE launches a new multiply on the cycle the FSM returns to IDLE.
- Latency, from the start-sampled edge to the done cycle inclusive:
  - 36 cycles minimum (no add/sub in any iteration)
  - 52 cycles maximum (add or sub in every iteration)
  - general: 1 + 16*2 + (number of add/sub iterations) + 3
- An illegal or unused state encoding recovers to IDLE on the next edge.

Optional Feature:
BOOTH_CYCCNT_EN
- Defined: adds output port cyc_cnt[5:0].
  - Cleared to 0 in LOAD.
  - Increments on every edge where busy=1.
  - Frozen at its final value after DONE until the next LOAD.
  - Reset value 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- q0=q_1=0 held, start pulse -> 16 SHIFT cycles, add=sub=0 throughout, done high exactly 36 cycles after the start edge, c_up pulsed 16 times.
- q0=1, q_1=0 held -> 16 SUB/SHIFT pairs, done at cycle 52; with BOOTH_CYCCNT_EN, cyc_cnt reads 52 after done and holds.
- Drive cnt from a real counter instance with q0/q_1 alternating 01/10 -> OUT_HI is entered immediately after the SHIFT where cnt=15, and cnt reads 0 afterwards.
- start pulsed again at cycle 10 of an active multiply -> no restart; done still occurs exactly once at the original expected cycle.
- rst asserted during ADD in iteration 7 -> same cycle: all outputs 0, state IDLE; a subsequent start gives a full 36-cycle run with q0=q_1=0.
- start held high continuously -> back-to-back multiplies, LOAD entered one cycle after each done, busy low for exactly one cycle (IDLE) between runs.

Source files
------------

// File: rtl/booth_seq_ctrl_if.sv
// Handshake and datapath-strobe bundle between the Booth sequencer and its
// surroundings (control unit, iteration counter, A/Q/M registers).
interface booth_seq_ctrl_if #(
    parameter int unsigned CNT_W = 4
);
    logic             start;
    logic             q0;
    logic             q_1;
    logic [CNT_W-1:0] cnt;

    logic             cnt_clr;
    logic             c_up;
    logic             ld_m;
    logic             ld_q;
    logic             clr_a;
    logic             add;
    logic             sub;
    logic             shift;
    logic             out_hi;
    logic             out_lo;
    logic             busy;
    logic             done;

    // Environment side: control unit, counter and datapath.
    modport master (
        output start, q0, q_1, cnt,
        input  cnt_clr, c_up, ld_m, ld_q, clr_a, add, sub, shift,
               out_hi, out_lo, busy, done
    );

    // Sequencer side.
    modport slave (
        input  start, q0, q_1, cnt,
        output cnt_clr, c_up, ld_m, ld_q, clr_a, add, sub, shift,
               out_hi, out_lo, busy, done
    );
endinterface

// File: rtl/booth_seq_ctrl.sv
// Moore control sequencer for the radix-2 Booth 16x16 multiplier.
// Optional macro BOOTH_CYCCNT_EN adds a 6-bit busy-cycle counter output.
module booth_seq_ctrl #(
    parameter int unsigned CNT_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    booth_seq_ctrl_if.slave   bus
`ifdef BOOTH_CYCCNT_EN
    ,
    output logic [5:0]        cyc_cnt
`endif
);

    localparam logic [CNT_W-1:0] CNT_LAST = '1;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_LOAD   = 4'd1,
        S_CHECK  = 4'd2,
        S_ADD    = 4'd3,
        S_SUB    = 4'd4,
        S_SHIFT  = 4'd5,
        S_OUT_HI = 4'd6,
        S_OUT_LO = 4'd7,
        S_DONE   = 4'd8
    } state_t;

    state_t state;
    state_t nxt;

    // Next-state decode; unused encodings fall back to IDLE.
    always_comb begin
        nxt = S_IDLE;
        case (state)
            S_IDLE:   nxt = bus.start ? S_LOAD : S_IDLE;
            S_LOAD:   nxt = S_CHECK;
            S_CHECK: begin
                case ({bus.q0, bus.q_1})
                    2'b01:   nxt = S_ADD;
                    2'b10:   nxt = S_SUB;
                    default: nxt = S_SHIFT;
                endcase
            end
            S_ADD:    nxt = S_SHIFT;
            S_SUB:    nxt = S_SHIFT;
            // cnt is the pre-increment value; the counter wraps on this edge.
            S_SHIFT:  nxt = (bus.cnt == CNT_LAST) ? S_OUT_HI : S_CHECK;
            S_OUT_HI: nxt = S_OUT_LO;
            S_OUT_LO: nxt = S_DONE;
            S_DONE:   nxt = S_IDLE;
            default:  nxt = S_IDLE;
        endcase
    end

    // State register with outputs registered from the next-state decode,
    // so each strobe is a pure function of the state held in that cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            bus.cnt_clr <= 1'b0;
            bus.c_up    <= 1'b0;
            bus.ld_m    <= 1'b0;
            bus.ld_q    <= 1'b0;
            bus.clr_a   <= 1'b0;
            bus.add     <= 1'b0;
            bus.sub     <= 1'b0;
            bus.shift   <= 1'b0;
            bus.out_hi  <= 1'b0;
            bus.out_lo  <= 1'b0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
        end else begin
            state       <= nxt;
            bus.cnt_clr <= (nxt == S_LOAD);
            bus.c_up    <= (nxt == S_SHIFT);
            bus.ld_m    <= (nxt == S_LOAD);
            bus.ld_q    <= (nxt == S_LOAD);
            bus.clr_a   <= (nxt == S_LOAD);
            bus.add     <= (nxt == S_ADD);
            bus.sub     <= (nxt == S_SUB);
            bus.shift   <= (nxt == S_SHIFT);
            bus.out_hi  <= (nxt == S_OUT_HI);
            bus.out_lo  <= (nxt == S_OUT_LO);
            bus.busy    <= (nxt != S_IDLE);
            bus.done    <= (nxt == S_DONE);
        end
    end

`ifdef BOOTH_CYCCNT_EN
    // Zero while in LOAD, then counts every busy edge; holds once idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_cnt <= 6'd0;
        end else if (nxt == S_LOAD) begin
            cyc_cnt <= 6'd0;
        end else if (bus.busy) begin
            cyc_cnt <= cyc_cnt + 6'd1;
        end
    end
`endif

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Directed self-checking bench for booth_seq_ctrl with a behavioural
// iteration counter driving cnt.
module tb_booth_seq_ctrl;

    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [CNT_W-1:0] cnt_q;
    int               total = 0;
    int               bad   = 0;

    booth_seq_ctrl_if #(.CNT_W(CNT_W)) bus ();

`ifdef BOOTH_CYCCNT_EN
    logic [5:0] cyc_cnt;
`endif

    booth_seq_ctrl #(.CNT_W(CNT_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus)
`ifdef BOOTH_CYCCNT_EN
        ,
        .cyc_cnt(cyc_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Register-file iteration counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)              cnt_q <= '0;
        else if (bus.cnt_clr) cnt_q <= '0;
        else if (bus.c_up)    cnt_q <= cnt_q + 4'd1;
    end
    assign bus.cnt = cnt_q;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] all_outs();
        return {bus.cnt_clr, bus.c_up, bus.ld_m, bus.ld_q, bus.clr_a, bus.add,
                bus.sub, bus.shift, bus.out_hi, bus.out_lo, bus.busy, bus.done};
    endfunction

    // One multiply launched by a start pulse; cycle 1 is the LOAD cycle.
    task automatic run_mult(input string tag, input logic [1:0] qq, input bit alt,
                            input int exp_done, input int exp_add, input int exp_sub,
                            input bit pulse_mid);
        int   done_at = 0;
        int   n_done  = 0;
        int   n_up    = 0;
        int   n_add   = 0;
        int   n_sub   = 0;
        int   n_excl  = 0;
        int   n_hi    = 0;
        int   n_hi_ok = 0;
        logic last15  = 1'b0;
        {bus.q0, bus.q_1} = qq;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check({tag, "_load"}, 32'(bus.ld_m & bus.ld_q & bus.clr_a & bus.cnt_clr & bus.busy), 32'd1);
        for (int c = 2; c <= 60; c++) begin
            @(posedge clk); #1;
            bus.start = pulse_mid && (c == 10);
            if (bus.out_hi) begin
                n_hi++;
                if (last15 && bus.cnt == 4'd0) n_hi_ok++;
            end
            last15 = bus.shift && (bus.cnt == 4'd15);
            if (bus.c_up) n_up++;
            if (bus.add)  n_add++;
            if (bus.sub)  n_sub++;
            if (int'(bus.add) + int'(bus.sub) + int'(bus.shift) + int'(bus.out_hi) + int'(bus.out_lo) > 1)
                n_excl++;
            if (bus.done) begin
                n_done++;
                done_at = c;
            end
            if (alt && bus.shift) {bus.q0, bus.q_1} = ~{bus.q0, bus.q_1};
        end
        bus.start = 1'b0;
        check({tag, "_done_cycle"}, 32'(done_at), 32'(exp_done));
        check({tag, "_done_count"}, 32'(n_done), 32'd1);
        check({tag, "_c_up"}, 32'(n_up), 32'd16);
        check({tag, "_adds"}, 32'(n_add), 32'(exp_add));
        check({tag, "_subs"}, 32'(n_sub), 32'(exp_sub));
        check({tag, "_excl"}, 32'(n_excl), 32'd0);
        check({tag, "_out_hi_after_cnt15"}, 32'(n_hi_ok), 32'd1);
        check({tag, "_idle_after"}, 32'(all_outs()), 32'd0);
`ifdef BOOTH_CYCCNT_EN
        check({tag, "_cyc_cnt"}, 32'(cyc_cnt), 32'(exp_done));
`endif
    endtask

    initial begin
        int n_add;
        int done1;
        int done2;
        int busy_low;
        int ld_at;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.q0    = 1'b0;
        bus.q_1   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outs", 32'(all_outs()), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_reset_idle", 32'(all_outs()), 32'd0);

        run_mult("q00", 2'b00, 1'b0, 36, 0, 0, 1'b0);
        run_mult("q11", 2'b11, 1'b0, 36, 0, 0, 1'b0);
        run_mult("q10", 2'b10, 1'b0, 52, 0, 16, 1'b0);
        run_mult("q01", 2'b01, 1'b0, 52, 16, 0, 1'b0);
        run_mult("alt", 2'b01, 1'b1, 52, 8, 8, 1'b0);
        run_mult("mid_start", 2'b00, 1'b0, 36, 0, 0, 1'b1);

        // Asynchronous reset while ADD of iteration 7 is active.
        {bus.q0, bus.q_1} = 2'b01;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        n_add = 0;
        for (int c = 0; c < 40 && n_add < 7; c++) begin
            @(posedge clk); #1;
            if (bus.add) n_add++;
        end
        check("rst_reached_add7", 32'(n_add), 32'd7);
        rst = 1'b1;
        #1;
        check("rst_same_cycle", 32'(all_outs()), 32'd0);
        @(posedge clk); #1;
        check("rst_held", 32'(all_outs()), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_released", 32'(all_outs()), 32'd0);
        run_mult("after_rst", 2'b00, 1'b0, 36, 0, 0, 1'b0);

        // start held high: back-to-back multiplies.
        {bus.q0, bus.q_1} = 2'b00;
        bus.start = 1'b1;
        @(posedge clk); #1;
        check("b2b_load1", 32'(bus.ld_m), 32'd1);
        done1 = 0; done2 = 0; busy_low = 0; ld_at = 0;
        for (int c = 2; c <= 73; c++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                if (done1 == 0) done1 = c;
                else if (done2 == 0) done2 = c;
            end
            if (!bus.busy) busy_low++;
            if (bus.ld_m && ld_at == 0) ld_at = c;
        end
        bus.start = 1'b0;
        check("b2b_done1", 32'(done1), 32'd36);
        check("b2b_busy_low", 32'(busy_low), 32'd1);
        check("b2b_load2", 32'(ld_at), 32'd38);
        check("b2b_done2", 32'(done2), 32'd73);
        repeat (3) @(posedge clk);
        #1;
        check("b2b_idle", 32'(all_outs()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
